// File: rtl/mx_bc_stream_pkg.sv
// ---------------------------------------------------------------------------
// alu_core_pkg
// Definitions shared by the MX ALU blocks:
//   t_scalar_datatype      - scalar operand encoding (BFLOAT16, FLOAT32)
//   SCALING_BLOCK_SIZE     - default number of elements per MX block
//   MX_SCALE_DATA_BITS     - width of an E8M0 shared scale
//   MXINT8_ELEMENT_BITS    - width of an MXINT8 element
//   MX_NAN_SCALE           - E8M0 encoding of NaN
//   t_mx_bc_state          - state encoding of the scalar broadcaster
//   bf16_to_e8int8()       - BF16 -> {scale, element}
//   fp32_rne_bf16()        - FP32 -> BF16 (RNE) -> {scale, element}
// ---------------------------------------------------------------------------
package alu_core_pkg;

    typedef enum logic [1:0] {
        BFLOAT16 = 2'd0,
        FLOAT32  = 2'd1
    } t_scalar_datatype;

    localparam int LARGEST_FLOAT_WIDTH = 32;
    localparam int SCALING_BLOCK_SIZE  = 32;
    localparam int MX_SCALE_DATA_BITS  = 8;
    localparam int MXINT8_ELEMENT_BITS = 8;

    localparam logic [MX_SCALE_DATA_BITS-1:0] MX_NAN_SCALE = 8'hFF;

    typedef enum logic {
        MX_BC_IDLE = 1'b0,
        MX_BC_EMIT = 1'b1
    } t_mx_bc_state;

    // BF16 -> {E8M0 scale, INT8 element}.
    // The element is the 7-bit significand {1, m[6:1]} (value 64..127), so the
    // BF16 exponent can be used directly as the shared scale. The dropped
    // mantissa bit m[0] is the only guard bit, so rounding is RNE without sticky.
    function automatic logic [15:0] bf16_to_e8int8(input logic [15:0] bf16);
        logic       sgn;
        logic [7:0] exp_v;
        logic [6:0] keep;
        logic [7:0] mag;
        logic [7:0] elem;
        logic [15:0] result;
        sgn    = bf16[15];
        exp_v  = bf16[14:7];
        keep   = {1'b1, bf16[6:1]};
        mag    = {1'b0, keep} + {7'd0, (bf16[0] & keep[0])};
        result = 16'h0000;
        if (exp_v == 8'h00) begin
            // Zero and denormals flush to zero.
            result = 16'h0000;
        end else if (exp_v == 8'hFF) begin
            result = {MX_NAN_SCALE, 8'h00};
        end else begin
            // Rounding carried out of the significand: renormalise.
            if (mag == 8'd128) begin
                mag   = 8'd64;
                exp_v = exp_v + 8'd1;
            end
            if (exp_v == 8'hFF) begin
                result = {MX_NAN_SCALE, 8'h00};
            end else begin
                elem   = sgn ? (8'd0 - mag) : mag;
                result = {exp_v, elem};
            end
        end
        return result;
    endfunction

    // FP32 -> BF16 with round-to-nearest-even on bit 16.
    // NaN is kept quiet and unrounded so it can never round into Inf.
    function automatic logic [15:0] fp32_round_bf16(input logic [31:0] fp32);
        logic        is_nan;
        logic        round_up;
        logic [15:0] result;
        is_nan   = (fp32[30:23] == 8'hFF) && (fp32[22:0] != 23'd0);
        round_up = fp32[15] & ((|fp32[14:0]) | fp32[16]);
        if (is_nan) begin
            result = fp32[31:16] | 16'h0040;
        end else begin
            result = fp32[31:16] + {15'd0, round_up};
        end
        return result;
    endfunction

    function automatic logic [15:0] fp32_rne_bf16(input logic [31:0] fp32);
        return bf16_to_e8int8(fp32_round_bf16(fp32));
    endfunction

endpackage

// File: rtl/mx_bc_stream_convert.sv
// ---------------------------------------------------------------------------
// mx_bc_convert
// Combinational scalar -> {E8M0 scale, INT8 element} conversion.
// Configuration macro: MX_BC_FP32_EN
//   defined   - FLOAT32 scalars are rounded to BF16 and converted.
//   undefined - FP32 rounding is not built; FLOAT32 yields scale=0xFF, elem=0.
// Ports:
//   datatype  in   scalar encoding
//   scalar    in   scalar bits (BF16 in [15:0])
//   scale     out  E8M0 shared scale
//   element   out  INT8 element
// ---------------------------------------------------------------------------
module mx_bc_convert
    import alu_core_pkg::*;
(
    input  t_scalar_datatype                   datatype,
    input  logic [LARGEST_FLOAT_WIDTH-1:0]     scalar,
    output logic [MX_SCALE_DATA_BITS-1:0]      scale,
    output logic [MXINT8_ELEMENT_BITS-1:0]     element
);

    logic [15:0] result;

`ifndef MX_BC_FP32_EN
    // Upper scalar bits only matter for FP32, which is not built here.
    logic unused_upper;
    assign unused_upper = ^scalar[LARGEST_FLOAT_WIDTH-1:16];
`endif

    always_comb begin
        result = {MX_NAN_SCALE, 8'h00};
        case (datatype)
            BFLOAT16: result = bf16_to_e8int8(scalar[15:0]);
`ifdef MX_BC_FP32_EN
            FLOAT32:  result = fp32_rne_bf16(scalar);
`else
            FLOAT32:  result = {MX_NAN_SCALE, 8'h00};
`endif
            default:  result = {MX_NAN_SCALE, 8'h00};
        endcase
    end

    assign scale   = result[15:8];
    assign element = result[7:0];

endmodule

// File: rtl/mx_bc_stream.sv
// ---------------------------------------------------------------------------
// mx_bc_stream
// Scalar-to-MXINT8 broadcaster. Accepts one scalar per input handshake,
// converts it to an E8M0 scale plus one INT8 element, and emits
// max(in_num_blocks,1) identical MX blocks of K elements.
// Configuration macro: MX_BC_FP32_EN (see mx_bc_convert).
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Valid never depends on ready; once out_valid is high, out_vector and
// out_last hold until the transfer. in_ready is high in IDLE, and in EMIT
// only while the last block is being taken (out_last && out_ready), so a new
// request can follow with no bubble.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  scalar request handshake
//   in_datatype     BFLOAT16 or FLOAT32
//   in_scalar       scalar bits (BF16 in [15:0])
//   in_num_blocks   blocks to emit (0 is treated as 1)
//   out_valid/ready output block handshake
//   out_vector      [7:0] = scale, element i at [8+8i +: 8]
//   out_last        final block of the current request
//   state           current FSM state (debug)
// ---------------------------------------------------------------------------
module mx_bc_stream
    import alu_core_pkg::*;
#(
    parameter  int K     = SCALING_BLOCK_SIZE,
    parameter  int CNT_W = 8,
    localparam int VEC_W = MX_SCALE_DATA_BITS + K*MXINT8_ELEMENT_BITS
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  t_scalar_datatype                in_datatype,
    input  logic [LARGEST_FLOAT_WIDTH-1:0]  in_scalar,
    input  logic [CNT_W-1:0]                in_num_blocks,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [VEC_W-1:0]                out_vector,
    output logic                            out_last,
    output t_mx_bc_state                    state
);

    logic [MX_SCALE_DATA_BITS-1:0]  cv_scale;
    logic [MXINT8_ELEMENT_BITS-1:0] cv_element;
    logic [MX_SCALE_DATA_BITS-1:0]  scale_q;
    logic [MXINT8_ELEMENT_BITS-1:0] element_q;
    logic [CNT_W-1:0]               remaining;
    logic [CNT_W-1:0]               num_eff;
    logic                           load;
    logic                           out_fire;

    mx_bc_convert u_convert (
        .datatype (in_datatype),
        .scalar   (in_scalar),
        .scale    (cv_scale),
        .element  (cv_element)
    );

    assign num_eff  = (in_num_blocks == '0) ? CNT_W'(1) : in_num_blocks;
    assign in_ready = (state == MX_BC_IDLE) || (out_last && out_ready);
    assign load     = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MX_BC_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            scale_q   <= '0;
            element_q <= '0;
            remaining <= '0;
        end else begin
            case (state)
                MX_BC_IDLE: begin
                    if (load) begin
                        state     <= MX_BC_EMIT;
                        out_valid <= 1'b1;
                        out_last  <= (num_eff == CNT_W'(1));
                        scale_q   <= cv_scale;
                        element_q <= cv_element;
                        remaining <= num_eff;
                    end
                end
                MX_BC_EMIT: begin
                    if (out_fire) begin
                        if (out_last) begin
                            if (load) begin
                                // Back-to-back request: reload without IDLE.
                                out_valid <= 1'b1;
                                out_last  <= (num_eff == CNT_W'(1));
                                scale_q   <= cv_scale;
                                element_q <= cv_element;
                                remaining <= num_eff;
                            end else begin
                                state     <= MX_BC_IDLE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                remaining <= '0;
                            end
                        end else begin
                            remaining <= remaining - CNT_W'(1);
                            // remaining==2 now means one beat left after this one.
                            out_last  <= (remaining == CNT_W'(2));
                        end
                    end
                end
                default: begin
                    state     <= MX_BC_IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    remaining <= '0;
                end
            endcase
        end
    end

    // Broadcast: every element slot carries the same value.
    assign out_vector = {{K{element_q}}, scale_q};

endmodule

// File: tb/tb_mx_bc_stream.sv
// ---------------------------------------------------------------------------
// tb_mx_bc_stream
// Directed bench for mx_bc_stream. Inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_mx_bc_stream;
    import alu_core_pkg::*;

    localparam int K     = SCALING_BLOCK_SIZE;
    localparam int CNT_W = 8;
    localparam int VEC_W = MX_SCALE_DATA_BITS + K*MXINT8_ELEMENT_BITS;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    t_scalar_datatype in_datatype;
    logic [31:0]      in_scalar;
    logic [CNT_W-1:0] in_num_blocks;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_vector;
    logic             out_last;
    t_mx_bc_state     state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mx_bc_stream #(.K(K), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_datatype   (in_datatype),
        .in_scalar     (in_scalar),
        .in_num_blocks (in_num_blocks),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_vector    (out_vector),
        .out_last      (out_last),
        .state         (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected block built from an expected scale and element.
    function automatic logic [VEC_W-1:0] build_vec(input logic [7:0] s, input logic [7:0] e);
        logic [VEC_W-1:0] v;
        v = '0;
        v[7:0] = s;
        for (int i = 0; i < K; i++) v[8+8*i +: 8] = e;
        return v;
    endfunction

    // ---------------- driver ----------------
    // Presents one request for one cycle from IDLE; returns 1ns after the
    // falling edge that follows acceptance, i.e. in the first output cycle.
    task automatic issue(input logic [1:0] dt, input logic [31:0] sc, input logic [7:0] nb);
        @(negedge clk);
        in_valid      = 1'b1;
        in_datatype   = t_scalar_datatype'(dt);
        in_scalar     = sc;
        in_num_blocks = nb;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_datatype = BFLOAT16; in_scalar = 32'h3F80; in_num_blocks = 8'd2;
        repeat (3) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_last !== 1'b0) $display("FAIL reset_out_last got=%b exp=0", out_last); else pass_cnt++;
        total_cnt++; if (out_vector !== '0) $display("FAIL reset_out_vector got=%h exp=0", out_vector[15:0]); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (state !== MX_BC_IDLE) $display("FAIL reset_state got=%0d exp=0", state); else pass_cnt++;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        issue(2'd0, 32'h0000_3F80, 8'd1);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_vector !== build_vec(8'h7F, 8'h40)) $display("FAIL single_vector got=%h exp=%h", out_vector[23:0], 24'h40407F); else pass_cnt++;
        total_cnt++; if (out_last !== 1'b1) $display("FAIL single_last got=%b exp=1", out_last); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_done_valid got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_convert();
        logic [1:0]  dts [15];
        logic [31:0] scs [15];
        logic [15:0] exs [15];
        dts = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2,
                2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        scs = '{32'h0000_3FFF, 32'h0000_3F81, 32'h0000_7F7F, 32'h0000_0000,
                32'h0000_0001, 32'hDEAD_3F80, 32'h0000_FF80, 32'h0000_C040,
                32'h0000_3F80, 32'h3F80_8000, 32'h3F81_8000, 32'h3F82_8001,
                32'h3F82_8000, 32'h7F80_0001, 32'h7F7F_FFFF};
`ifdef MX_BC_FP32_EN
        exs = '{16'h8040, 16'h7F40, 16'hFF00, 16'h0000, 16'h0000, 16'h7F40,
                16'hFF00, 16'h80A0, 16'hFF00, 16'h7F40, 16'h7F41, 16'h7F42,
                16'h7F41, 16'hFF00, 16'hFF00};
`else
        exs = '{16'h8040, 16'h7F40, 16'hFF00, 16'h0000, 16'h0000, 16'h7F40,
                16'hFF00, 16'h80A0, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
                16'hFF00, 16'hFF00, 16'hFF00};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            issue(dts[i], scs[i], 8'd1);
            total_cnt++;
            if (out_valid !== 1'b1 || out_vector !== build_vec(exs[i][15:8], exs[i][7:0]))
                $display("FAIL convert_%0d in=%h got valid=%b scale=%h elem=%h exp scale=%h elem=%h",
                         i, scs[i], out_valid, out_vector[7:0], out_vector[15:8], exs[i][15:8], exs[i][7:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [4:0] pat;
        int beats;
        pat = 5'b10101;
        beats = 0;
        out_ready = 1'b1;
        issue(2'd0, 32'h0000_BFC0, 8'd3);
        for (int c = 0; c < 12 && beats < 3; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = (c < 5) ? pat[c] : 1'b1;
            #1;
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_valid cycle=%0d got=%b exp=1", c, out_valid); else pass_cnt++;
            total_cnt++; if (out_vector !== build_vec(8'h7F, 8'hA0)) $display("FAIL stall_vector cycle=%0d got=%h exp=%h", c, out_vector[23:0], 24'hA0A07F); else pass_cnt++;
            total_cnt++; if (out_last !== (beats == 2)) $display("FAIL stall_last cycle=%0d got=%b exp=%b", c, out_last, (beats == 2)); else pass_cnt++;
            if (out_ready) beats++;
        end
        @(negedge clk); out_ready = 1'b1; #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_extra_beat got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (beats !== 3) $display("FAIL stall_beats got=%0d exp=3", beats); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_datatype = BFLOAT16; in_scalar = 32'h3F80; in_num_blocks = 8'd2;
        @(negedge clk);
        in_valid = 1'b0; #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_first got=%b exp=0", in_ready); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b1; in_scalar = 32'hBFC0; in_num_blocks = 8'd0; #1;
        total_cnt++; if (out_last !== 1'b1) $display("FAIL b2b_last_first got=%b exp=1", out_last); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_last got=%b exp=1", in_ready); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0; #1;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_no_bubble got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_vector !== build_vec(8'h7F, 8'hA0)) $display("FAIL b2b_vector got=%h exp=%h", out_vector[23:0], 24'hA0A07F); else pass_cnt++;
        total_cnt++; if (out_last !== 1'b1) $display("FAIL b2b_last_second got=%b exp=1", out_last); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL b2b_idle got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_zero_blocks();
        int beats;
        beats = 0;
        out_ready = 1'b1;
        issue(2'd0, 32'h0000_4040, 8'd0);
        for (int c = 0; c < 8; c++) begin
            if (out_valid === 1'b1) beats++;
            @(negedge clk); #1;
        end
        total_cnt++; if (beats !== 1) $display("FAIL zero_blocks_beats got=%0d exp=1", beats); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int beats;
        beats = 0;
        out_ready = 1'b1;
        issue(2'd0, 32'h0000_3F80, 8'd4);
        @(negedge clk);
        rst = 1'b1; #1;
        total_cnt++; if (out_valid !== 1'b1 || out_last !== 1'b0) $display("FAIL rstmid_beat2 got valid=%b last=%b exp valid=1 last=0", out_valid, out_last); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (out_vector !== '0 || out_last !== 1'b0) $display("FAIL rstmid_outputs got vec=%h last=%b exp vec=0 last=0", out_vector[15:0], out_last); else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            if (out_valid === 1'b1) beats++;
            @(negedge clk); #1;
        end
        total_cnt++; if (beats !== 0) $display("FAIL rstmid_extra_beats got=%0d exp=0", beats); else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_convert();
        test_stall();
        test_back_to_back();
        test_zero_blocks();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
